// File: rtl/free_list.sv
// Circular free list of physical register tags: hands tags to rename from the head,
// takes retired tags back at the tail, and rolls the head back to per-branch checkpoints.
module free_list #(
  parameter int PHYS_REG_NUM = 64,
  parameter int ARCH_REG_NUM = 32,
  parameter int BRANCH_NUM   = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          alloc_req,
  output logic                                          alloc_grant,
  output logic [$clog2(PHYS_REG_NUM)-1:0]               alloc_reg,
  output logic                                          empty,
  output logic [$clog2(PHYS_REG_NUM-ARCH_REG_NUM+1)-1:0] free_count,
  input  logic                                          reclaim_valid,
  input  logic [$clog2(PHYS_REG_NUM)-1:0]               reclaim_reg,
  input  logic                                          checkpoint_valid,
  input  logic [$clog2(BRANCH_NUM)-1:0]                 checkpoint_id,
  input  logic                                          restore_valid,
  input  logic [$clog2(BRANCH_NUM)-1:0]                 restore_id,
  output logic                                          overflow_err
);

  localparam int DEPTH = PHYS_REG_NUM - ARCH_REG_NUM;
  localparam int PW    = $clog2(PHYS_REG_NUM);
  localparam int DW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  logic [PW-1:0] entry_q [DEPTH];
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] ckpt_q [BRANCH_NUM];
  logic [DW-1:0] ckpt_d [BRANCH_NUM];
  logic          overflow_q, overflow_d;

  logic          full;
  logic          reclaim_accept;
  logic [DW-1:0] head_inc;
  logic [DW-1:0] ckpt_sel;
  logic [CW-1:0] restore_dist;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [DW-1:0] wrap_inc(input logic [DW-1:0] ptr);
    return (ptr == DW'(DEPTH - 1)) ? '0 : ptr + DW'(1);
  endfunction

  assign full           = (count_q == CW'(DEPTH));
  assign empty          = (count_q == '0);
  assign free_count     = count_q;
  assign alloc_reg      = entry_q[head_q];
  assign alloc_grant    = alloc_req & ~empty & ~restore_valid;
  assign reclaim_accept = reclaim_valid & ~full;
  assign overflow_err   = overflow_q;
  assign head_inc       = wrap_inc(head_q);
  assign ckpt_sel       = ckpt_q[restore_id];

  // Wrong-path tag count: head distance past the snapshot, modulo DEPTH.
  always_comb begin
    if (head_q >= ckpt_sel) restore_dist = CW'(head_q - ckpt_sel);
    else                    restore_dist = CW'(head_q) + CW'(DEPTH) - CW'(ckpt_sel);
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    head_d     = head_q;
    tail_d     = tail_q;
    ckpt_d     = ckpt_q;
    overflow_d = overflow_q | (reclaim_valid & full);
    count_d    = count_q - CW'(alloc_grant) + CW'(reclaim_accept);

    if (restore_valid) begin
      head_d  = ckpt_sel;
      count_d = count_d + restore_dist;
    end else begin
      if (alloc_grant)      head_d = head_inc;
      if (checkpoint_valid) ckpt_d[checkpoint_id] = alloc_grant ? head_inc : head_q;
    end

    if (reclaim_accept) tail_d = wrap_inc(tail_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the tag storage is reset as well, because the list must come up holding the unmapped tags.
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= PW'(ARCH_REG_NUM + i);
      for (int b = 0; b < BRANCH_NUM; b++) ckpt_q[b] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= CW'(DEPTH);
      overflow_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ckpt_q     <= ckpt_d;
      overflow_q <= overflow_d;
      if (reclaim_accept) entry_q[tail_q] <= reclaim_reg;
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed scenarios plus a randomized run
// against a queue-based model of free, committed-eligible and wrong-path tags.
module tb_free_list;

  localparam int PHYS  = 64;
  localparam int ARCH  = 32;
  localparam int BR    = 4;
  localparam int DEPTH = PHYS - ARCH;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_req;
  logic       alloc_grant;
  logic [5:0] alloc_reg;
  logic       empty;
  logic [5:0] free_count;
  logic       reclaim_valid;
  logic [5:0] reclaim_reg;
  logic       checkpoint_valid;
  logic [1:0] checkpoint_id;
  logic       restore_valid;
  logic [1:0] restore_id;
  logic       overflow_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  free_list #(.PHYS_REG_NUM(PHYS), .ARCH_REG_NUM(ARCH), .BRANCH_NUM(BR)) dut (
    .clk              (clk),
    .rst              (rst),
    .alloc_req        (alloc_req),
    .alloc_grant      (alloc_grant),
    .alloc_reg        (alloc_reg),
    .empty            (empty),
    .free_count       (free_count),
    .reclaim_valid    (reclaim_valid),
    .reclaim_reg      (reclaim_reg),
    .checkpoint_valid (checkpoint_valid),
    .checkpoint_id    (checkpoint_id),
    .restore_valid    (restore_valid),
    .restore_id       (restore_id),
    .overflow_err     (overflow_err)
  );

  task automatic set_idle();
    rst              = 1'b0;
    alloc_req        = 1'b0;
    reclaim_valid    = 1'b0;
    reclaim_reg      = '0;
    checkpoint_valid = 1'b0;
    checkpoint_id    = '0;
    restore_valid    = 1'b0;
    restore_id       = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    rst           = 1'b1;
    alloc_req     = 1'b1;
    reclaim_valid = 1'b1;
    reclaim_reg   = 6'd3;
    tick();
    set_idle();
    alloc_req = 1'b1;
    #1;
    n_checks++; if (alloc_reg !== 6'd32) begin n_fail++; $display("FAIL reset_alloc_reg: got %0d want 32", alloc_reg); end
    n_checks++; if (free_count !== 6'd32) begin n_fail++; $display("FAIL reset_free_count: got %0d want 32", free_count); end
    n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL reset_empty: got %0b want 0", empty); end
    n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b want 0", overflow_err); end
    n_checks++; if (alloc_grant !== 1'b1) begin n_fail++; $display("FAIL reset_grant: got %0b want 1", alloc_grant); end
    alloc_req = 1'b0;
  endtask

  task automatic test_fill_empty();
    alloc_req = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_checks++; if (alloc_grant !== 1'b1) begin n_fail++; $display("FAIL fill_grant[%0d]: got %0b want 1", i, alloc_grant); end
      n_checks++; if (alloc_reg !== 6'(ARCH + i)) begin n_fail++; $display("FAIL fill_tag[%0d]: got %0d want %0d", i, alloc_reg, ARCH + i); end
      tick();
    end
    #1;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fill_empty: got %0b want 1", empty); end
    n_checks++; if (free_count !== 6'd0) begin n_fail++; $display("FAIL fill_count: got %0d want 0", free_count); end
    n_checks++; if (alloc_grant !== 1'b0) begin n_fail++; $display("FAIL fill_extra_grant: got %0b want 0", alloc_grant); end
    alloc_req = 1'b0;
  endtask

  task automatic test_reclaim_from_empty();
    int tags [3] = '{5, 9, 12};
    for (int k = 0; k < 3; k++) begin
      reclaim_valid = 1'b1;
      reclaim_reg   = 6'(tags[k]);
      tick();
    end
    reclaim_valid = 1'b0;
    #1;
    n_checks++; if (free_count !== 6'd3) begin n_fail++; $display("FAIL reclaim_count: got %0d want 3", free_count); end
    alloc_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (alloc_grant !== 1'b1 || alloc_reg !== 6'(tags[k])) begin
        n_fail++; $display("FAIL reclaim_alloc[%0d]: got grant %0b tag %0d want grant 1 tag %0d", k, alloc_grant, alloc_reg, tags[k]);
      end
      tick();
    end
    reclaim_valid = 1'b1;
    reclaim_reg   = 6'd20;
    #1;
    n_checks++; if (alloc_grant !== 1'b0) begin n_fail++; $display("FAIL no_bypass_grant: got %0b want 0", alloc_grant); end
    tick();
    reclaim_valid = 1'b0;
    #1;
    n_checks++; if (alloc_grant !== 1'b1 || alloc_reg !== 6'd20) begin
      n_fail++; $display("FAIL reclaim_next_cycle: got grant %0b tag %0d want grant 1 tag 20", alloc_grant, alloc_reg);
    end
    tick();
    alloc_req = 1'b0;
    #1;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reclaim_reempty: got %0b want 1", empty); end
  endtask

  task automatic test_checkpoint_restore();
    do_reset();
    alloc_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (alloc_reg !== 6'(32 + i)) begin n_fail++; $display("FAIL ckpt_pre_alloc[%0d]: got %0d want %0d", i, alloc_reg, 32 + i); end
      tick();
    end
    checkpoint_valid = 1'b1;
    checkpoint_id    = 2'd2;
    #1;
    n_checks++; if (alloc_grant !== 1'b1 || alloc_reg !== 6'd35) begin
      n_fail++; $display("FAIL ckpt_same_cycle_alloc: got grant %0b tag %0d want grant 1 tag 35", alloc_grant, alloc_reg);
    end
    tick();
    checkpoint_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (alloc_reg !== 6'(36 + i)) begin n_fail++; $display("FAIL ckpt_wrong_path[%0d]: got %0d want %0d", i, alloc_reg, 36 + i); end
      tick();
    end
    alloc_req = 1'b0;
    #1;
    n_checks++; if (free_count !== 6'd26) begin n_fail++; $display("FAIL ckpt_pre_restore_count: got %0d want 26", free_count); end
    restore_valid = 1'b1;
    restore_id    = 2'd2;
    tick();
    restore_valid = 1'b0;
    #1;
    n_checks++; if (free_count !== 6'd28) begin n_fail++; $display("FAIL restore_count: got %0d want 28", free_count); end
    n_checks++; if (alloc_reg !== 6'd36) begin n_fail++; $display("FAIL restore_head_tag: got %0d want 36", alloc_reg); end
  endtask

  task automatic test_wrap();
    int exp_tags [4] = '{62, 63, 0, 1};
    do_reset();
    alloc_req = 1'b1;
    repeat (30) tick();
    alloc_req = 1'b0;
    for (int i = 0; i < 30; i++) begin
      reclaim_valid = 1'b1;
      reclaim_reg   = 6'(i);
      tick();
    end
    reclaim_valid = 1'b0;
    #1;
    n_checks++; if (free_count !== 6'd32) begin n_fail++; $display("FAIL wrap_refill_count: got %0d want 32", free_count); end
    checkpoint_valid = 1'b1;
    checkpoint_id    = 2'd1;
    tick();
    checkpoint_valid = 1'b0;
    alloc_req        = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (alloc_reg !== 6'(exp_tags[k])) begin n_fail++; $display("FAIL wrap_alloc[%0d]: got %0d want %0d", k, alloc_reg, exp_tags[k]); end
      tick();
    end
    alloc_req = 1'b0;
    #1;
    n_checks++; if (free_count !== 6'd28) begin n_fail++; $display("FAIL wrap_pre_restore_count: got %0d want 28", free_count); end
    restore_valid = 1'b1;
    restore_id    = 2'd1;
    tick();
    restore_valid = 1'b0;
    #1;
    n_checks++; if (free_count !== 6'd32) begin n_fail++; $display("FAIL wrap_restore_count: got %0d want 32", free_count); end
    n_checks++; if (alloc_reg !== 6'd62) begin n_fail++; $display("FAIL wrap_restore_tag: got %0d want 62", alloc_reg); end
  endtask

  // Continues from the wrap scenario: head = tail = 30, list full.
  task automatic test_concurrent();
    alloc_req = 1'b1;
    repeat (2) tick();
    alloc_req        = 1'b0;
    checkpoint_valid = 1'b1;
    checkpoint_id    = 2'd3;
    tick();
    checkpoint_valid = 1'b0;
    alloc_req        = 1'b1;
    repeat (3) tick();
    alloc_req = 1'b0;
    #1;
    n_checks++; if (free_count !== 6'd27) begin n_fail++; $display("FAIL conc_pre_count: got %0d want 27", free_count); end
    restore_valid    = 1'b1;
    restore_id       = 2'd3;
    alloc_req        = 1'b1;
    reclaim_valid    = 1'b1;
    reclaim_reg      = 6'd40;
    checkpoint_valid = 1'b1;
    checkpoint_id    = 2'd3;
    #1;
    n_checks++; if (alloc_grant !== 1'b0) begin n_fail++; $display("FAIL conc_grant: got %0b want 0", alloc_grant); end
    tick();
    set_idle();
    #1;
    n_checks++; if (free_count !== 6'd31) begin n_fail++; $display("FAIL conc_count: got %0d want 31", free_count); end
    n_checks++; if (alloc_reg !== 6'd0) begin n_fail++; $display("FAIL conc_head_tag: got %0d want 0", alloc_reg); end
    alloc_req = 1'b1;
    repeat (2) tick();
    alloc_req     = 1'b0;
    restore_valid = 1'b1;
    restore_id    = 2'd3;
    tick();
    restore_valid = 1'b0;
    #1;
    n_checks++; if (free_count !== 6'd31) begin n_fail++; $display("FAIL conc_ckpt_kept_count: got %0d want 31", free_count); end
    n_checks++; if (alloc_reg !== 6'd0) begin n_fail++; $display("FAIL conc_ckpt_kept_tag: got %0d want 0", alloc_reg); end
  endtask

  task automatic test_overflow();
    set_idle();
    rst       = 1'b1;
    alloc_req = 1'b1;
    tick();
    set_idle();
    reclaim_valid = 1'b1;
    reclaim_reg   = 6'd7;
    alloc_req     = 1'b1;
    #1;
    n_checks++; if (alloc_grant !== 1'b1) begin n_fail++; $display("FAIL ovf_grant: got %0b want 1", alloc_grant); end
    tick();
    set_idle();
    #1;
    n_checks++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %0b want 1", overflow_err); end
    n_checks++; if (free_count !== 6'd31) begin n_fail++; $display("FAIL ovf_count: got %0d want 31", free_count); end
    n_checks++; if (alloc_reg !== 6'd33) begin n_fail++; $display("FAIL ovf_head_tag: got %0d want 33", alloc_reg); end
    tick();
    n_checks++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b want 1", overflow_err); end
    reclaim_valid = 1'b1;
    reclaim_reg   = 6'd50;
    tick();
    reclaim_valid = 1'b0;
    alloc_req     = 1'b1;
    repeat (31) tick();
    alloc_req = 1'b0;
    #1;
    n_checks++; if (alloc_reg !== 6'd50 || free_count !== 6'd1) begin
      n_fail++; $display("FAIL ovf_storage: got tag %0d count %0d want tag 50 count 1", alloc_reg, free_count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared: got %0b want 0", overflow_err); end
    n_checks++; if (alloc_reg !== 6'd32) begin n_fail++; $display("FAIL ovf_reset_tag: got %0d want 32", alloc_reg); end
  endtask

  // Model: fq = free tags in hand-out order; pool = tags committed-eligible;
  // spec = tags allocated after the live checkpoint, in allocation order.
  task automatic test_random();
    int  fq[$];
    int  pool[$];
    int  spec[$];
    bit  live = 1'b0;
    int  live_id = 0;
    bit  exp_grant;
    int  idx;
    do_reset();
    for (int t = ARCH; t < PHYS; t++) fq.push_back(t);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      set_idle();
      alloc_req = ($urandom_range(99) < 60);
      if (live && spec.size() >= DEPTH - 1) alloc_req = 1'b0;
      if (pool.size() > 0 && $urandom_range(99) < 45) begin
        idx           = int'($urandom_range(pool.size() - 1));
        reclaim_valid = 1'b1;
        reclaim_reg   = 6'(pool[idx]);
        pool.delete(idx);
      end
      if (!live && $urandom_range(99) < 10) begin
        checkpoint_valid = 1'b1;
        checkpoint_id    = 2'($urandom_range(BR - 1));
      end
      if (live && $urandom_range(99) < 8) begin
        restore_valid = 1'b1;
        restore_id    = 2'(live_id);
      end
      #1;
      exp_grant = alloc_req && (fq.size() > 0) && !restore_valid;
      n_checks++; if (alloc_grant !== exp_grant) begin n_fail++; $display("FAIL rand_grant@%0d: got %0b want %0b", cyc, alloc_grant, exp_grant); end
      n_checks++; if (free_count !== 6'(fq.size())) begin n_fail++; $display("FAIL rand_count@%0d: got %0d want %0d", cyc, free_count, fq.size()); end
      n_checks++; if (empty !== (fq.size() == 0)) begin n_fail++; $display("FAIL rand_empty@%0d: got %0b want %0b", cyc, empty, fq.size() == 0); end
      n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL rand_overflow@%0d: got %0b want 0", cyc, overflow_err); end
      if (fq.size() > 0) begin
        n_checks++; if (alloc_reg !== 6'(fq[0])) begin n_fail++; $display("FAIL rand_tag@%0d: got %0d want %0d", cyc, alloc_reg, fq[0]); end
      end
      tick();
      if (reclaim_valid) fq.push_back(int'(reclaim_reg));
      if (restore_valid) begin
        for (int k = spec.size() - 1; k >= 0; k--) fq.push_front(spec[k]);
        spec.delete();
        live = 1'b0;
      end else begin
        if (exp_grant) begin
          if (live) spec.push_back(fq.pop_front());
          else      pool.push_back(fq.pop_front());
        end
        if (checkpoint_valid) begin
          live    = 1'b1;
          live_id = int'(checkpoint_id);
        end
      end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_fill_empty();
    test_reclaim_from_empty();
    test_checkpoint_restore();
    test_wrap();
    test_concurrent();
    test_overflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
